vga_fb_reader: RTL



---
 rtl/vga_fb_reader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/vga_fb_reader.sv
// 640x480@60 VGA timing generator and 1bpp framebuffer reader.
// Fetches 64-pixel groups over NUMREAD combinational read ports and double-buffers them.
module vga_fb_reader #(
    parameter int               DATA    = 8,
    parameter int               ADDR    = 16,
    parameter int               NUMREAD = 8,
    parameter logic [ADDR-1:0]  BASE    = '0,
    parameter logic [11:0]      FG      = 12'hFFF,
    parameter logic [11:0]      BG      = 12'h000
) (
    input  logic                          clk,
    input  logic                          rst_L,
    input  logic                          pix_en,
    output logic [NUMREAD-1:0][ADDR-1:0]  b_addr,
    output logic [NUMREAD-1:0]            b_re,
    input  logic [NUMREAD-1:0][DATA-1:0]  b_data,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          active,
    output logic [11:0]                   vga_rgb,
    output logic                          frame_start
);
    localparam logic [ADDR-1:0] ROW_BYTES = ADDR'(80);

    logic [9:0]                   h_q, h_d, v_q, v_d;
    logic [ADDR-1:0]              row_base_q, row_base_d;
    logic                         hsync_q, hsync_d, vsync_q, vsync_d;
    logic                         active_q, active_d, frame_start_q, frame_start_d;
    logic [11:0]                  vga_rgb_q, vga_rgb_d;
    logic [NUMREAD-1:0]           b_re_q, b_re_d;
    logic [NUMREAD-1:0][ADDR-1:0] b_addr_q, b_addr_d;
    logic [NUMREAD-1:0][DATA-1:0] cur_buf_q, cur_buf_d, pend_buf_q, pend_buf_d;

    logic            pix_bit, trig1, trig2, swap;
    logic [ADDR-1:0] grp_off, next_base, fetch_base;

    always_comb begin
        pix_bit    = cur_buf_q[h_q[5:3]][3'd7 - h_q[2:0]];
        trig1      = (v_q < 10'd480) && (h_q < 10'd576) && (h_q[5:0] == 6'd32);
        trig2      = (h_q == 10'd700) && ((v_q == 10'd524) || (v_q < 10'd479));
        swap       = ((h_q < 10'd639) && (h_q[5:0] == 6'd63)) || (h_q == 10'd799);
        // T1 fetches the group after the one being displayed, hence the +1.
        grp_off    = ADDR'({h_q[9:6] + 4'd1, 3'b000});
        // row_base tracks BASE + v*80; next_base is the following row's base.
        next_base  = (v_q == 10'd524) ? BASE : row_base_q + ROW_BYTES;
        fetch_base = trig1 ? row_base_q + grp_off : next_base;

        h_d           = h_q;
        v_d           = v_q;
        row_base_d    = row_base_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        active_d      = active_q;
        vga_rgb_d     = vga_rgb_q;
        frame_start_d = 1'b0;
        b_re_d        = '0;
        b_addr_d      = b_addr_q;
        cur_buf_d     = cur_buf_q;
        pend_buf_d    = pend_buf_q;

        if (pix_en) begin
            hsync_d       = !((h_q >= 10'd656) && (h_q <= 10'd751));
            vsync_d       = !((v_q == 10'd490) || (v_q == 10'd491));
            active_d      = (h_q < 10'd640) && (v_q < 10'd480);
            vga_rgb_d     = active_d ? (pix_bit ? FG : BG) : 12'h000;
            frame_start_d = (h_q == 10'd0) && (v_q == 10'd0);

            if (h_q == 10'd799) begin
                h_d        = 10'd0;
                v_d        = (v_q == 10'd524) ? 10'd0 : v_q + 10'd1;
                row_base_d = next_base;
            end else begin
                h_d = h_q + 10'd1;
            end

            if (swap) cur_buf_d = pend_buf_q;

            if (trig1 || trig2) begin
                b_re_d = '1;
                for (int i = 0; i < NUMREAD; i++) b_addr_d[i] = fetch_base + ADDR'(i);
            end
        end

        if (b_re_q != '0) pend_buf_d = b_data;
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            h_q           <= '0;
            v_q           <= '0;
            row_base_q    <= BASE;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            active_q      <= 1'b0;
            vga_rgb_q     <= '0;
            frame_start_q <= 1'b0;
            b_re_q        <= '0;
            b_addr_q      <= '0;
            cur_buf_q     <= '0;
            pend_buf_q    <= '0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            row_base_q    <= row_base_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            vga_rgb_q     <= vga_rgb_d;
            frame_start_q <= frame_start_d;
            b_re_q        <= b_re_d;
            b_addr_q      <= b_addr_d;
            cur_buf_q     <= cur_buf_d;
            pend_buf_q    <= pend_buf_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign vga_rgb     = vga_rgb_q;
    assign frame_start = frame_start_q;
    assign b_re        = b_re_q;
    assign b_addr      = b_addr_q;
endmodule
